// File: rtl/vga_obj_pkg.sv
// Shared constants for the VGA object controller: 640x480 timing, register
// offsets and fixed object colours.
package vga_obj_pkg;

   localparam int H_ACT   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;

   localparam int V_ACT   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

   localparam logic [15:0] PIPE_BASE = 16'h000;
   localparam logic [15:0] BIRD_OFS  = 16'h100;
   localparam logic [15:0] CTRL_OFS  = 16'h104;
   localparam logic [15:0] STAT_OFS  = 16'h108;
   localparam logic [15:0] BG_OFS    = 16'h10C;

   localparam logic [11:0] BIRD_RGB  = 12'hFF0;
   localparam logic [11:0] PIPE_RGB  = 12'h0F0;

endpackage

// File: rtl/vga_timing.sv
// 640x480 scan generator: pixel-enable divider, h/v counters and raw
// (unregistered) sync/active/vblank-start indications for the current count.
module vga_timing
   import vga_obj_pkg::*;
#(
   parameter int PIX_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pix_tick,
   output logic [9:0] h,
   output logic [9:0] v,
   output logic       active,
   output logic       hs_raw,
   output logic       vs_raw,
   output logic       vblank_start
);

   localparam int DW = $clog2(PIX_DIV);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_BEG = 10'(H_ACT + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACT + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACT + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACT + V_FP + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    h_q, h_d, v_q, v_d;

   // Tick on the last divider phase, so the first tick lands PIX_DIV clocks after reset.
   assign pix_tick = (div_q == DW'(PIX_DIV - 1));

   always_comb begin
      div_d = pix_tick ? '0 : div_q + 1'b1;
      h_d   = h_q;
      v_d   = v_q;
      if (pix_tick) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   assign h            = h_q;
   assign v            = v_q;
   assign active       = (h_q < 10'(H_ACT)) && (v_q < 10'(V_ACT));
   assign hs_raw       = !((h_q >= HS_BEG) && (h_q < HS_END));
   assign vs_raw       = !((v_q >= VS_BEG) && (v_q < VS_END));
   assign vblank_start = pix_tick && (h_q == '0) && (v_q == 10'(V_ACT));

endmodule

// File: rtl/vga_obj_ctrl.sv
// Memory-mapped VGA object controller: double-buffered pipe/bird registers,
// scan timing and renderer. Define VGA_COLLISION_EN for the sticky collision flag.
module vga_obj_ctrl
   import vga_obj_pkg::*;
#(
   parameter int         NUM_PIPES = 2,
   parameter int         COORD_W   = 10,
   parameter int         PIX_DIV   = 4,
   parameter logic [3:0] BASE_SEL  = 4'h1,
   parameter int         PIPE_W    = 52,
   parameter int         GAP_H     = 120,
   parameter int         BIRD_X    = 100,
   parameter int         BIRD_SIZE = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic        ena,
   output logic [31:0] rdata,
   output logic        hs,
   output logic        vs,
   output logic [11:0] rgb,
   output logic        frame_irq
);

   // Edge sums need one bit beyond the coordinate, and at least enough for h/v.
   localparam int EW = (COORD_W + 1 > 11) ? COORD_W + 1 : 11;

   typedef logic [COORD_W-1:0] coord_t;

   logic        pix_tick, active, hs_raw, vs_raw, vblank_start;
   logic [9:0]  h, v;

   vga_timing #(.PIX_DIV(PIX_DIV)) u_timing (
      .clk          (clk),
      .rst_n        (rst_n),
      .pix_tick     (pix_tick),
      .h            (h),
      .v            (v),
      .active       (active),
      .hs_raw       (hs_raw),
      .vs_raw       (vs_raw),
      .vblank_start (vblank_start)
   );

   coord_t      px_sh_q [NUM_PIPES];
   coord_t      gy_sh_q [NUM_PIPES];
   coord_t      px_q    [NUM_PIPES];
   coord_t      gy_q    [NUM_PIPES];
   coord_t      bird_sh_q, bird_q;
   logic [11:0] bg_q, rgb_q;
   logic [15:0] fcnt_q;
   logic        en_q, pend_q, pend_d, irq_q, hs_q, vs_q, col_bit;

   logic        sel, commit;
   logic [15:0] ofs;

   assign sel = (addr[31:28] == BASE_SEL);
   assign ofs = addr[15:0];
   assign ena = we && sel;

   logic unused_bits;
   assign unused_bits = ^{addr, wdata};

   always_comb begin
      rdata = '0;
      if (sel) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            if (ofs == PIPE_BASE + 16'(8*i))     rdata = 32'(px_sh_q[i]);
            if (ofs == PIPE_BASE + 16'(8*i + 4)) rdata = 32'(gy_sh_q[i]);
         end
         case (ofs)
            BIRD_OFS: rdata = 32'(bird_sh_q);
            CTRL_OFS: rdata = {30'b0, pend_q, en_q};
            STAT_OFS: rdata = {fcnt_q, 13'b0, col_bit, pend_q, (v >= 10'(V_ACT))};
            BG_OFS:   rdata = {20'b0, bg_q};
            default:  ;
         endcase
      end
   end

   // A commit write in the vblank-start clock wins over the clear.
   assign commit = vblank_start && pend_q;
   always_comb begin
      pend_d = pend_q;
      if (commit)                                pend_d = 1'b0;
      if (ena && ofs == CTRL_OFS && wdata[1])    pend_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            px_sh_q[i] <= '0;
            gy_sh_q[i] <= '0;
            px_q[i]    <= '0;
            gy_q[i]    <= '0;
         end
         bird_sh_q <= '0;
         bird_q    <= '0;
         bg_q      <= '0;
         en_q      <= 1'b0;
         pend_q    <= 1'b0;
         fcnt_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            if (ena && ofs == PIPE_BASE + 16'(8*i))     px_sh_q[i] <= wdata[COORD_W-1:0];
            if (ena && ofs == PIPE_BASE + 16'(8*i + 4)) gy_sh_q[i] <= wdata[COORD_W-1:0];
            if (commit) begin
               px_q[i] <= px_sh_q[i];
               gy_q[i] <= gy_sh_q[i];
            end
         end
         if (ena && ofs == BIRD_OFS) bird_sh_q <= wdata[COORD_W-1:0];
         if (commit)                 bird_q    <= bird_sh_q;
         if (ena && ofs == BG_OFS)   bg_q      <= wdata[11:0];
         if (ena && ofs == CTRL_OFS) en_q      <= wdata[0];
         if (vblank_start)           fcnt_q    <= fcnt_q + 16'd1;
         pend_q <= pend_d;
         irq_q  <= vblank_start;
      end
   end

   logic [EW-1:0]        x_e, y_e, by_e;
   logic                 in_bird;
   logic [NUM_PIPES-1:0] in_pipe;
   logic [11:0]          pix_rgb;

   assign x_e  = EW'(h);
   assign y_e  = EW'(v);
   assign by_e = EW'(bird_q);

   // y + SIZE > ybird rather than y > ybird - SIZE, so a low bird clips at row 0.
   assign in_bird = (x_e >= EW'(BIRD_X)) && (x_e < EW'(BIRD_X + BIRD_SIZE)) &&
                    (y_e <= by_e) && (y_e + EW'(BIRD_SIZE) > by_e);

   for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
      logic [EW-1:0] px_e, gy_e;
      assign px_e       = EW'(px_q[g]);
      assign gy_e       = EW'(gy_q[g]);
      assign in_pipe[g] = (x_e >= px_e) && (x_e < px_e + EW'(PIPE_W)) &&
                          ((y_e < gy_e) || (y_e >= gy_e + EW'(GAP_H)));
   end

   assign pix_rgb = in_bird    ? BIRD_RGB :
                    |in_pipe   ? PIPE_RGB : bg_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
      end else if (pix_tick) begin
         rgb_q <= (active && en_q) ? pix_rgb : '0;
         hs_q  <= hs_raw;
         vs_q  <= vs_raw;
      end
   end

`ifdef VGA_COLLISION_EN
   logic col_q, col_d;
   always_comb begin
      col_d = col_q;
      if (ena && ofs == STAT_OFS && wdata[2])       col_d = 1'b0;
      if (pix_tick && active && in_bird && |in_pipe) col_d = 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) col_q <= 1'b0;
      else        col_q <= col_d;
   end
   assign col_bit = col_q;
`else
   assign col_bit = 1'b0;
`endif

   assign rgb       = rgb_q;
   assign hs        = hs_q;
   assign vs        = vs_q;
   assign frame_irq = irq_q;

endmodule

// File: tb/tb_vga_obj_ctrl.sv
// Scoreboard bench for vga_obj_ctrl: pixel expectations are queued with their
// frame/x/y and checked when the DUT's output for that pixel appears.
module tb_vga_obj_ctrl;

   localparam int P  = 2;
   localparam int CW = 10;
   localparam logic [31:0] A_PIPE0X = 32'h1000_0000;
   localparam logic [31:0] A_PIPE0Y = 32'h1000_0004;
   localparam logic [31:0] A_BIRD   = 32'h1000_0100;
   localparam logic [31:0] A_CTRL   = 32'h1000_0104;
   localparam logic [31:0] A_STAT   = 32'h1000_0108;
   localparam logic [31:0] A_BG     = 32'h1000_010C;
   localparam logic [11:0] BG       = 12'h123;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] addr, wdata, rdata;
   logic        we, ena, hs, vs, frame_irq;
   logic [11:0] rgb;

   vga_obj_ctrl #(.NUM_PIPES(2), .COORD_W(CW), .PIX_DIV(P)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we),
      .ena(ena), .rdata(rdata), .hs(hs), .vs(vs), .rgb(rgb), .frame_irq(frame_irq)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Posedges since the last reset release.
   longint cyc;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   // Sync edge recorder, armed after the final reset release.
   logic   armed = 1'b0;
   logic   hs_p = 1'b1, vs_p = 1'b1;
   longint hsf [2], hsr [1], vsf [2], vsr [1];
   int     hsf_n = 0, hsr_n = 0, vsf_n = 0, vsr_n = 0;
   always @(negedge clk) begin
      hs_p <= hs;
      vs_p <= vs;
      if (armed) begin
         if (hs_p && !hs && hsf_n < 2) begin hsf[hsf_n] <= cyc; hsf_n <= hsf_n + 1; end
         if (!hs_p && hs && hsr_n < 1) begin hsr[0]     <= cyc; hsr_n <= hsr_n + 1; end
         if (vs_p && !vs && vsf_n < 2) begin vsf[vsf_n] <= cyc; vsf_n <= vsf_n + 1; end
         if (!vs_p && vs && vsr_n < 1) begin vsr[0]     <= cyc; vsr_n <= vsr_n + 1; end
      end
   end

   typedef struct {int f; int x; int y; logic [11:0] exp;} pix_t;
   pix_t   sbq [$];
   longint e0 = 0;

   function automatic longint tgt(input int f, input int x, input int y);
      return e0 + longint'((f*525 + y)*800 + x) * P;
   endfunction

   task automatic expect_pix(input int f, input int x, input int y, input logic [11:0] e);
      pix_t p;
      p.f = f; p.x = x; p.y = y; p.exp = e;
      sbq.push_back(p);
   endtask

   initial forever begin
      @(negedge clk);
      if (armed && sbq.size() > 0) begin
         longint t;
         t = tgt(sbq[0].f, sbq[0].x, sbq[0].y);
         if (cyc == t) begin
            chk($sformatf("pix f%0d (%0d,%0d)", sbq[0].f, sbq[0].x, sbq[0].y), 32'(rgb), 32'(sbq[0].exp));
            void'(sbq.pop_front());
         end else if (cyc > t) begin
            chk($sformatf("pix late f%0d (%0d,%0d)", sbq[0].f, sbq[0].x, sbq[0].y), 32'(cyc), 32'(t));
            void'(sbq.pop_front());
         end
      end
   end

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic exp_ena);
      @(negedge clk);
      addr = a; wdata = d; we = 1'b1;
      #1 chk($sformatf("ena wr %h", a), 32'(ena), 32'(exp_ena));
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp);
      addr = a; we = 1'b0;
      #1 chk($sformatf("rd %h", a), rdata, exp);
   endtask

   task automatic wait_cyc(input longint t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_irq(input longint exp_at, input string tag);
      while (!frame_irq && cyc < exp_at + 1000) @(negedge clk);
      chk({tag, " at"}, 32'(cyc), 32'(exp_at));
      @(negedge clk);
      chk({tag, " width"}, 32'(frame_irq), 32'd0);
   endtask

   initial begin
      addr = '0; wdata = '0; we = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst rgb", 32'(rgb), 32'h0);
      chk("rst hs", 32'(hs), 32'd1);
      chk("rst vs", 32'(vs), 32'd1);
      chk("rst irq", 32'(frame_irq), 32'd0);
      rst_n = 1'b1;

      // Dirty some state, then reset in the middle of the first hsync pulse.
      bus_wr(A_PIPE0X, 32'd5, 1'b1);
      bus_wr(A_CTRL, 32'd3, 1'b1);
      wait_cyc(700*P);
      chk("pre-rst hs", 32'(hs), 32'd0);
      #1 rst_n = 1'b0;
      #1 chk("midrst hs", 32'(hs), 32'd1);
      chk("midrst vs", 32'(vs), 32'd1);
      chk("midrst rgb", 32'(rgb), 32'h0);
      bus_rd(A_PIPE0X, 32'h0);
      bus_rd(A_CTRL, 32'h0);
      bus_rd(A_STAT, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      armed = 1'b1;

      bus_wr(A_PIPE0X, 32'h1234_0ABC, 1'b1);
      bus_rd(A_PIPE0X, 32'h0ABC & ((32'd1 << CW) - 1));
      chk("ena rd", 32'(ena), 32'd0);
      bus_wr(A_BIRD, 32'h1000_00FF, 1'b1);
      bus_rd(A_BIRD, 32'h0FF);
      bus_rd(32'h1000_0200, 32'h0);
      bus_wr(32'h1000_0010, 32'h55, 1'b1);
      bus_rd(32'h1000_0010, 32'h0);
      bus_wr(32'h2000_0000, 32'h77, 1'b0);
      bus_rd(A_PIPE0X, 32'h2BC);
      bus_rd(A_STAT, 32'h0);

      bus_wr(A_PIPE0X, 32'd200, 1'b1);
      bus_wr(A_PIPE0Y, 32'd100, 1'b1);
      bus_wr(A_BIRD, 32'd250, 1'b1);
      bus_wr(A_BG, 32'(BG), 1'b1);
      bus_wr(A_CTRL, 32'd3, 1'b1);
      bus_rd(A_PIPE0Y, 32'd100);
      bus_rd(A_STAT, 32'h2);

      while (hsf_n < 1 && cyc < 2000*P) @(negedge clk);
      if (hsf_n < 1) begin
         $display("FAIL hs never fell after reset");
         $fatal(1, "no hsync");
      end
      chk("hs first fall", 32'((hsf[0] > 656*P) && (hsf[0] <= 657*P)), 32'd1);
      e0 = hsf[0] - 656*P;

      // Frame 0 still renders the reset-time active regs (pipe x=0 gy=0).
      expect_pix(0, 30, 300, 12'h0F0);
      expect_pix(0, 5, 479, 12'h0F0);

      wait_irq(tgt(0, 0, 480), "irq1");
      bus_rd(A_STAT, 32'h0001_0001);

      expect_pix(1, 700, 10, 12'h000);
      expect_pix(1, 210, 50, 12'h0F0);
      expect_pix(1, 210, 150, BG);
      expect_pix(1, 105, 245, 12'hFF0);
      expect_pix(1, 105, 250, 12'hFF0);
      expect_pix(1, 105, 251, BG);

      wait_cyc(tgt(1, 0, 300));
      bus_wr(A_CTRL, 32'd0, 1'b1);
`ifdef VGA_COLLISION_EN
      bus_wr(A_PIPE0X, 32'd90, 1'b1);
      bus_wr(A_PIPE0Y, 32'd300, 1'b1);
      bus_wr(A_CTRL, 32'd2, 1'b1);
`endif
      expect_pix(1, 210, 400, 12'h000);

      wait_irq(tgt(1, 0, 480), "irq2");

      while (vsf_n < 2 && cyc < tgt(1, 0, 500)) @(negedge clk);
      chk("vs falls seen", 32'(vsf_n), 32'd2);
      bus_rd(A_STAT, 32'h0002_0001);
      chk("hs low width", 32'(hsr[0] - hsf[0]), 32'(96*P));
      chk("line period", 32'(hsf[1] - hsf[0]), 32'(800*P));
      chk("vs first fall", 32'(vsf[0]), 32'(tgt(0, 0, 490)));
      chk("vs low width", 32'(vsr[0] - vsf[0]), 32'(2*800*P));
      chk("frame period", 32'(vsf[1] - vsf[0]), 32'(525*800*P));

      bus_wr(A_STAT, 32'h4, 1'b1);
      bus_rd(A_STAT, 32'h0002_0001);

`ifdef VGA_COLLISION_EN
      wait_cyc(tgt(2, 0, 252));
      bus_rd(A_STAT, 32'h0002_0004);
      bus_wr(A_STAT, 32'h4, 1'b1);
      bus_rd(A_STAT, 32'h0002_0000);
      wait_cyc(tgt(3, 0, 252));
      bus_rd(A_STAT, 32'h0003_0004);
`endif

      while (sbq.size() > 0 && cyc < tgt(4, 0, 0)) @(negedge clk);
      chk("scoreboard drained", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
